// File: rtl/exe_mem_if.sv
// EXE->MEM boundary bundle: ID->EXE operands/control in, forwarding tap and
// registered MEM-stage fields out. The slave modport is the pipe itself.
interface exe_mem_if;
   logic [15:0] immediate_EXE;
   logic [15:0] valueA_EXE;
   logic [15:0] valueB_EXE;
   logic [15:0] PC_EXE;
   logic [2:0]  Rd_EXE;
   logic [10:0] EXE_signals;
   logic [15:0] AluResult_EXE;
   logic [15:0] AluResult_MEM;
   logic [15:0] valueB_MEM;
   logic [15:0] immediate_MEM;
   logic [15:0] PC_MEM;
   logic [2:0]  Rd_MEM;
   logic [7:0]  MEM_signals;

   modport master (
      output immediate_EXE, valueA_EXE, valueB_EXE, PC_EXE, Rd_EXE, EXE_signals,
      input  AluResult_EXE, AluResult_MEM, valueB_MEM, immediate_MEM, PC_MEM,
             Rd_MEM, MEM_signals
   );

   modport slave (
      input  immediate_EXE, valueA_EXE, valueB_EXE, PC_EXE, Rd_EXE, EXE_signals,
      output AluResult_EXE, AluResult_MEM, valueB_MEM, immediate_MEM, PC_MEM,
             Rd_MEM, MEM_signals
   );
endinterface

// File: rtl/exe_mem_pipe.sv
// Execute-stage ALU plus EXE->MEM pipeline register of the 16-bit pipeline.
// Optional macro EXE_MEM_FLUSH_EN adds a synchronous flush that bubbles MEM_signals.
module exe_mem_pipe (
   input  logic      clk,
   input  logic      rst_n,
`ifdef EXE_MEM_FLUSH_EN
   input  logic      flush,
`endif
   exe_mem_if.slave  bus
);

   localparam logic [1:0] ALU_AND  = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
   localparam logic [1:0] ALU_PASS = 2'b11;

   logic        w_alu_src;
   logic [1:0]  w_alu_op;
   logic [15:0] w_op2;
   logic [15:0] w_alu_result;
   logic [7:0]  w_mem_sig_next;

   logic [15:0] r_alu_result;
   logic [15:0] r_value_b;
   logic [15:0] r_immediate;
   logic [15:0] r_pc;
   logic [2:0]  r_rd;
   logic [7:0]  r_mem_signals;

   assign w_alu_src = bus.EXE_signals[10];
   assign w_alu_op  = bus.EXE_signals[9:8];

   // Operand select and ALU; carries and borrows fall off the 16-bit result.
   always_comb begin
      w_op2        = 16'h0000;
      w_alu_result = 16'h0000;
      if (w_alu_src) begin
         w_op2 = bus.immediate_EXE;
      end else begin
         w_op2 = bus.valueB_EXE;
      end
      case (w_alu_op)
         ALU_AND:  w_alu_result = bus.valueA_EXE & w_op2;
         ALU_ADD:  w_alu_result = bus.valueA_EXE + w_op2;
         ALU_SUB:  w_alu_result = bus.valueA_EXE - w_op2;
         ALU_PASS: w_alu_result = w_op2;
         default:  w_alu_result = 16'h0000;
      endcase
   end

   // Control word for the MEM slot; a flushed slot becomes a bubble.
   always_comb begin
      w_mem_sig_next = bus.EXE_signals[7:0];
`ifdef EXE_MEM_FLUSH_EN
      if (flush) begin
         w_mem_sig_next = 8'h00;
      end else begin
         w_mem_sig_next = bus.EXE_signals[7:0];
      end
`endif
   end

   // EXE->MEM register: loads every edge, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_result  <= 16'h0000;
         r_value_b     <= 16'h0000;
         r_immediate   <= 16'h0000;
         r_pc          <= 16'h0000;
         r_rd          <= 3'b000;
         r_mem_signals <= 8'h00;
      end else begin
         r_alu_result  <= w_alu_result;
         r_value_b     <= bus.valueB_EXE;
         r_immediate   <= bus.immediate_EXE;
         r_pc          <= bus.PC_EXE;
         r_rd          <= bus.Rd_EXE;
         r_mem_signals <= w_mem_sig_next;
      end
   end

   assign bus.AluResult_EXE = w_alu_result;
   assign bus.AluResult_MEM = r_alu_result;
   assign bus.valueB_MEM    = r_value_b;
   assign bus.immediate_MEM = r_immediate;
   assign bus.PC_MEM        = r_pc;
   assign bus.Rd_MEM        = r_rd;
   assign bus.MEM_signals   = r_mem_signals;

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Self-checking bench for exe_mem_pipe: reference model plus directed vectors.
module tb_exe_mem_pipe;

   logic clk;
   logic rst_n;
   logic flush;

   exe_mem_if bus ();

   exe_mem_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef EXE_MEM_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // expected registered state, from the rule "capture inputs at each edge"
   logic [15:0] m_alu, m_b, m_imm, m_pc;
   logic [2:0]  m_rd;
   logic [7:0]  m_sig;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] imm, input logic [10:0] sig);
      int unsigned o, r;
      o = sig[10] ? int'(imm) : int'(b);
      case (sig[9:8])
         2'd0:    r = int'(a) & o;
         2'd1:    r = (int'(a) + o) % 65536;
         2'd2:    r = (int'(a) + 65536 - o) % 65536;
         default: r = o;
      endcase
      return r[15:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_alu <= 16'h0000; m_b <= 16'h0000; m_imm <= 16'h0000;
         m_pc  <= 16'h0000; m_rd <= 3'd0;    m_sig <= 8'h00;
      end else begin
         m_alu <= ref_alu(bus.valueA_EXE, bus.valueB_EXE, bus.immediate_EXE, bus.EXE_signals);
         m_b   <= bus.valueB_EXE;
         m_imm <= bus.immediate_EXE;
         m_pc  <= bus.PC_EXE;
         m_rd  <= bus.Rd_EXE;
         m_sig <= flush ? 8'h00 : bus.EXE_signals[7:0];
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("alu_exe", bus.AluResult_EXE,
          ref_alu(bus.valueA_EXE, bus.valueB_EXE, bus.immediate_EXE, bus.EXE_signals));
      chk("alu_mem", bus.AluResult_MEM, m_alu);
      chk("valb_mem", bus.valueB_MEM, m_b);
      chk("imm_mem", bus.immediate_MEM, m_imm);
      chk("pc_mem", bus.PC_MEM, m_pc);
      chk("rd_mem", {13'd0, bus.Rd_MEM}, {13'd0, m_rd});
      chk("sig_mem", {8'd0, bus.MEM_signals}, {8'd0, m_sig});
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                        input logic [15:0] pc, input logic [2:0] rd, input logic [10:0] sig);
      bus.valueA_EXE    = a;
      bus.valueB_EXE    = b;
      bus.immediate_EXE = imm;
      bus.PC_EXE        = pc;
      bus.Rd_EXE        = rd;
      bus.EXE_signals   = sig;
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_alu"}, bus.AluResult_MEM, 16'h0000);
      chk({tag, "_b"},   bus.valueB_MEM,    16'h0000);
      chk({tag, "_imm"}, bus.immediate_MEM, 16'h0000);
      chk({tag, "_pc"},  bus.PC_MEM,        16'h0000);
      chk({tag, "_rd"},  {13'd0, bus.Rd_MEM}, 16'h0000);
      chk({tag, "_sig"}, {8'd0, bus.MEM_signals}, 16'h0000);
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      drive(16'hAAAA, 16'h5555, 16'h1357, 16'h00FE, 3'd7, 11'h7FF);
      #3;
      zero_check("rst_noedge");
      step();
      zero_check("rst_edge");

      // release, then ADD with register operand
      rst_n = 1'b1;
      drive(16'h0005, 16'h0003, 16'h0000, 16'h0010, 3'd2, 11'h101);
      #1 chk("add_comb", bus.AluResult_EXE, 16'h0008);
      step();
      chk("add_mem", bus.AluResult_MEM, 16'h0008);
      chk("add_sig", {8'd0, bus.MEM_signals}, 16'h0001);

      drive(16'h0000, 16'h0001, 16'h0000, 16'h0011, 3'd3, 11'h201);
      step();
      chk("sub_wrap", bus.AluResult_MEM, 16'hFFFF);

      drive(16'h8000, 16'h0000, 16'h8000, 16'h0012, 3'd4, 11'h501);
      step();
      chk("add_wrap", bus.AluResult_MEM, 16'h0000);

      drive(16'hF0F0, 16'h1234, 16'h0FF0, 16'h0013, 3'd5, 11'h480);
      step();
      chk("and_imm", bus.AluResult_MEM, 16'h00F0);
      chk("and_valb", bus.valueB_MEM, 16'h1234);

      drive(16'hF0F0, 16'h1234, 16'h0FF0, 16'h0014, 3'd6, 11'h703);
      step();
      chk("pass_imm", bus.AluResult_MEM, 16'h0FF0);
      chk("pass_valb", bus.valueB_MEM, 16'h1234);

      // back-to-back: PC 0..3, Rd 1..4, one cycle behind each
      for (int i = 0; i < 4; i++) begin
         drive(16'(i * 3), 16'(i + 100), 16'h0000, 16'(i), 3'(i + 1), 11'h101);
         step();
         chk("b2b_pc", bus.PC_MEM, 16'(i));
         chk("b2b_rd", {13'd0, bus.Rd_MEM}, 16'(i + 1));
      end

      for (int i = 0; i < 12; i++) begin
         drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               3'($urandom), 11'($urandom));
         step();
      end

`ifdef EXE_MEM_FLUSH_EN
      flush = 1'b1;
      drive(16'h0002, 16'h0003, 16'h0000, 16'h0020, 3'd1, 11'h1FF);
      step();
      chk("flush_sig", {8'd0, bus.MEM_signals}, 16'h0000);
      chk("flush_alu", bus.AluResult_MEM, 16'h0005);
      flush = 1'b0;
      step();
      chk("noflush_sig", {8'd0, bus.MEM_signals}, 16'h00FF);
`endif

      // reset mid-operation, asserted between edges
      drive(16'h0100, 16'h0001, 16'h0000, 16'h0030, 3'd7, 11'h1AA);
      step();
      #1 rst_n = 1'b0;
      flush = 1'b1;
      #1 zero_check("rst_mid");
      chk("rst_mid_comb", bus.AluResult_EXE, 16'h0101);
      compare_all();
      step();
      zero_check("rst_hold");
      rst_n = 1'b1;
      flush = 1'b0;
      step();
      chk("rst_rel_pc", bus.PC_MEM, 16'h0030);
      chk("rst_rel_sig", {8'd0, bus.MEM_signals}, 16'h00AA);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
